// File: rtl/debug_display_ctrl.sv
// Debug readout controller: latches a switch address on a capture edge, reads the register file or data memory, and scans the result onto a multiplexed hex display.
// Optional leading-zero blanking is enabled by defining DBG_DISP_LZ_BLANK_EN.
module debug_display_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32,
    parameter int REFRESH_DIV = 50000,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic                  reg_sel,
    input  logic [ADDR_W-1:0]     addr_sw,
    output logic [31:0]           rd_addr,
    output logic                  reg_rd_en,
    output logic                  mem_rd_en,
    input  logic                  rd_valid,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic [DATA_W-1:0]     mem_data,
    output logic [NUM_DIGITS-1:0] digit_an,
    output logic [3:0]            digit_nib,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, SHOW} state_t;

    state_t             state;
    logic               capture_q;
    logic               armed;
    logic               sel_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0]  shown_val;
    logic [CNT_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic               cap_edge;
    logic               blank;

    function automatic logic [3:0] nib_at(input logic [DATA_W-1:0] v, input logic [IDX_W-1:0] idx);
        nib_at = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx == IDX_W'(i)) nib_at = v[4*i +: 4];
    endfunction

`ifdef DBG_DISP_LZ_BLANK_EN
    // Index of the highest nonzero displayed nibble; 0 when the value is zero so digit 0 stays lit.
    function automatic logic [IDX_W-1:0] top_nib(input logic [DATA_W-1:0] v);
        top_nib = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (v[4*i +: 4] != 4'h0) top_nib = IDX_W'(i);
    endfunction

    assign blank = (digit_idx > top_nib(shown_val));
`else
    assign blank = 1'b0;
`endif

    // armed masks the first clock after reset so a button held through reset is not seen as an edge.
    assign cap_edge = capture & ~capture_q & armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            capture_q   <= 1'b0;
            armed       <= 1'b0;
            sel_q       <= 1'b0;
            wait_cnt    <= '0;
            shown_val   <= '0;
            rd_addr     <= '0;
            reg_rd_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            capture_q <= capture;
            armed     <= 1'b1;
            case (state)
                IDLE, SHOW: begin
                    if (cap_edge) begin
                        state       <= REQ;
                        rd_addr     <= 32'(addr_sw);
                        sel_q       <= reg_sel;
                        reg_rd_en   <= reg_sel;
                        mem_rd_en   <= ~reg_sel;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                REQ: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    // rd_valid is checked first so it wins a tie with the timeout.
                    if (rd_valid) begin
                        shown_val <= sel_q ? reg_data : mem_data;
                        state     <= SHOW;
                        reg_rd_en <= 1'b0;
                        mem_rd_en <= 1'b0;
                        busy      <= 1'b0;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        shown_val   <= '0;
                        timeout_err <= 1'b1;
                        state       <= SHOW;
                        reg_rd_en   <= 1'b0;
                        mem_rd_en   <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            digit_an  <= '1;
            digit_nib <= 4'h0;
        end else begin
            if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            digit_an  <= blank ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
            digit_nib <= nib_at(shown_val, digit_idx);
        end
    end
endmodule

// File: tb/tb_debug_display_ctrl.sv
// Directed testbench for debug_display_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, TIMEOUT=8.
module tb_debug_display_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        capture = 1'b0;
    logic        reg_sel = 1'b0;
    logic [14:0] addr_sw = '0;
    logic [31:0] rd_addr;
    logic        reg_rd_en, mem_rd_en;
    logic        rd_valid = 1'b0;
    logic [31:0] reg_data = '0;
    logic [31:0] mem_data = '0;
    logic [3:0]  digit_an;
    logic [3:0]  digit_nib;
    logic        busy, timeout_err;

    int total = 0;
    int bad = 0;

    debug_display_ctrl #(
        .NUM_DIGITS(4), .ADDR_W(15), .DATA_W(32), .REFRESH_DIV(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .capture(capture), .reg_sel(reg_sel), .addr_sw(addr_sw),
        .rd_addr(rd_addr), .reg_rd_en(reg_rd_en), .mem_rd_en(mem_rd_en),
        .rd_valid(rd_valid), .reg_data(reg_data), .mem_data(mem_data),
        .digit_an(digit_an), .digit_nib(digit_nib), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] exp, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (digit_an === exp) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++; if (rd_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", rd_addr, 32'h0); end
        total++; if ({reg_rd_en, mem_rd_en, busy, timeout_err} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {reg_rd_en, mem_rd_en, busy, timeout_err}); end
        total++; if (digit_an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", digit_an); end
        total++; if (digit_nib !== 4'h0) begin bad++; $display("FAIL reset_nib got=%h exp=0", digit_nib); end
        tick(); tick();
        total++; if (digit_an !== 4'b1111) begin bad++; $display("FAIL reset_an_held got=%b exp=1111", digit_an); end
        rst = 1'b0;
        tick(); tick();
    endtask

    task automatic test_register_read();
        int en_cnt;
        bit ok;
        logic [3:0] exp_nib [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
        logic [3:0] e;
        addr_sw = 15'h0005; reg_sel = 1'b1; capture = 1'b1;
        tick();
        total++; if (rd_addr !== 32'h0000_0005) begin bad++; $display("FAIL rr_addr got=%h exp=%h", rd_addr, 32'h5); end
        total++; if ({busy, mem_rd_en} !== 2'b10) begin bad++; $display("FAIL rr_busy_mem got=%b exp=10", {busy, mem_rd_en}); end
        en_cnt = int'(reg_rd_en);
        repeat (3) begin tick(); en_cnt += int'(reg_rd_en); end
        rd_valid = 1'b1; reg_data = 32'h0000_ABCD;
        tick();
        rd_valid = 1'b0; capture = 1'b0;
        total++; if (en_cnt !== 4) begin bad++; $display("FAIL rr_en_cycles got=%0d exp=4", en_cnt); end
        total++; if ({reg_rd_en, busy} !== 2'b00) begin bad++; $display("FAIL rr_done got=%b exp=00", {reg_rd_en, busy}); end
        tick();
        for (int i = 0; i < 4; i++) begin
            e = ~(4'b0001 << i);
            wait_an(e, 12, ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_scan_to got=%b exp=%b", digit_an, e); end
            total++; if (digit_nib !== exp_nib[i]) begin bad++; $display("FAIL rr_digit%0d got=%h exp=%h", i, digit_nib, exp_nib[i]); end
        end
    endtask

    task automatic test_scan_wrap();
        bit ok;
        logic [3:0] e;
        wait_an(4'b1101, 12, ok);
        if (ok) wait_an(4'b1110, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL scan_sync got=%b exp=1110", digit_an); end
        for (int i = 0; i <= 16; i++) begin
            e = ~(4'b0001 << ((i / 4) % 4));
            total++; if (digit_an !== e) begin bad++; $display("FAIL scan_step%0d got=%b exp=%b", i, digit_an, e); end
            tick();
        end
    endtask

    task automatic test_timeout();
        int en_cnt;
        logic [3:0] nib_or;
        addr_sw = 15'h0010; reg_sel = 1'b0; capture = 1'b1;
        tick();
        total++; if ({mem_rd_en, reg_rd_en} !== 2'b10) begin bad++; $display("FAIL to_sel got=%b exp=10", {mem_rd_en, reg_rd_en}); end
        en_cnt = int'(mem_rd_en);
        repeat (8) begin tick(); en_cnt += int'(mem_rd_en); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy_w8 got=%b exp=1", busy); end
        tick();
        total++; if ({busy, mem_rd_en, timeout_err} !== 3'b001) begin bad++; $display("FAIL to_abort got=%b exp=001", {busy, mem_rd_en, timeout_err}); end
        total++; if (en_cnt !== 9) begin bad++; $display("FAIL to_en_cycles got=%0d exp=9", en_cnt); end
        tick();
        nib_or = 4'h0;
        repeat (16) begin nib_or |= digit_nib; tick(); end
        total++; if (nib_or !== 4'h0) begin bad++; $display("FAIL to_digits got=%h exp=0", nib_or); end
        capture = 1'b0;
        tick();
        addr_sw = 15'h0020; reg_sel = 1'b1; capture = 1'b1;
        tick();
        total++; if ({timeout_err, busy} !== 2'b01) begin bad++; $display("FAIL to_clear got=%b exp=01", {timeout_err, busy}); end
        total++; if (rd_addr !== 32'h0000_0020) begin bad++; $display("FAIL to_addr2 got=%h exp=%h", rd_addr, 32'h20); end
    endtask

    task automatic test_timeout_tie();
        bit ok;
        repeat (8) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tie_busy got=%b exp=1", busy); end
        rd_valid = 1'b1; reg_data = 32'h0000_1234;
        tick();
        rd_valid = 1'b0;
        total++; if ({busy, timeout_err} !== 2'b00) begin bad++; $display("FAIL tie_result got=%b exp=00", {busy, timeout_err}); end
        tick();
        wait_an(4'b1110, 20, ok);
        total++; if (!ok || digit_nib !== 4'h4) begin bad++; $display("FAIL tie_digit0 got=%h exp=4", digit_nib); end
    endtask

    task automatic test_ignored_edge();
        bit ok;
        capture = 1'b0;
        tick();
        addr_sw = 15'h0042; reg_sel = 1'b0; capture = 1'b1;
        tick();
        capture = 1'b0;
        tick();
        addr_sw = 15'h7FFF; reg_sel = 1'b1; capture = 1'b1;
        tick();
        total++; if (rd_addr !== 32'h0000_0042) begin bad++; $display("FAIL ign_addr got=%h exp=%h", rd_addr, 32'h42); end
        total++; if ({mem_rd_en, reg_rd_en, busy} !== 3'b101) begin bad++; $display("FAIL ign_ctrl got=%b exp=101", {mem_rd_en, reg_rd_en, busy}); end
        mem_data = 32'h0000_5678; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_done got=%b exp=0", busy); end
        tick(); tick();
        total++; if ({busy, reg_rd_en, mem_rd_en} !== 3'b000) begin bad++; $display("FAIL ign_no_second got=%b exp=000", {busy, reg_rd_en, mem_rd_en}); end
        total++; if (rd_addr !== 32'h0000_0042) begin bad++; $display("FAIL ign_addr_after got=%h exp=%h", rd_addr, 32'h42); end
        wait_an(4'b1110, 20, ok);
        total++; if (!ok || digit_nib !== 4'h8) begin bad++; $display("FAIL ign_digit0 got=%h exp=8", digit_nib); end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] nib_or;
        capture = 1'b0;
        tick();
        addr_sw = 15'h0099; reg_sel = 1'b1; capture = 1'b1;
        tick(); tick(); tick();
        total++; if (reg_rd_en !== 1'b1) begin bad++; $display("FAIL rmr_pre got=%b exp=1", reg_rd_en); end
        rst = 1'b1;
        #1;
        total++; if ({reg_rd_en, mem_rd_en, busy} !== 3'b000) begin bad++; $display("FAIL rmr_en got=%b exp=000", {reg_rd_en, mem_rd_en, busy}); end
        total++; if (digit_an !== 4'b1111) begin bad++; $display("FAIL rmr_an got=%b exp=1111", digit_an); end
        total++; if (rd_addr !== 32'h0) begin bad++; $display("FAIL rmr_addr got=%h exp=0", rd_addr); end
        rd_valid = 1'b1; reg_data = 32'hFFFF_FFFF;
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
        total++; if ({busy, reg_rd_en} !== 2'b00) begin bad++; $display("FAIL rmr_no_edge got=%b exp=00", {busy, reg_rd_en}); end
        rd_valid = 1'b0;
        nib_or = 4'h0;
        repeat (16) begin nib_or |= digit_nib; tick(); end
        total++; if (nib_or !== 4'h0) begin bad++; $display("FAIL rmr_no_capture got=%h exp=0", nib_or); end
        capture = 1'b0;
        tick();
    endtask

`ifdef DBG_DISP_LZ_BLANK_EN
    task automatic test_blanking();
        logic [3:0] seen;
        logic [3:0] n0, n1;
        logic blank_seen;
        for (int v = 0; v < 2; v++) begin
            capture = 1'b0;
            tick();
            reg_sel = 1'b1; addr_sw = 15'h0001; capture = 1'b1;
            tick(); tick();
            rd_valid = 1'b1; reg_data = (v == 0) ? 32'h0000_0012 : 32'h0;
            tick();
            rd_valid = 1'b0;
            tick();
            seen = 4'h0; blank_seen = 1'b0; n0 = 4'hF; n1 = 4'hF;
            repeat (24) begin
                for (int i = 0; i < 4; i++) if (digit_an === ~(4'b0001 << i)) seen[i] = 1'b1;
                if (digit_an === 4'b1111) blank_seen = 1'b1;
                if (digit_an === 4'b1110) n0 = digit_nib;
                if (digit_an === 4'b1101) n1 = digit_nib;
                tick();
            end
            if (v == 0) begin
                total++; if ({blank_seen, seen} !== 5'b10011) begin bad++; $display("FAIL blank12_an got=%b exp=10011", {blank_seen, seen}); end
                total++; if ({n1, n0} !== 8'h12) begin bad++; $display("FAIL blank12_nib got=%h exp=12", {n1, n0}); end
            end else begin
                total++; if ({blank_seen, seen} !== 5'b10001) begin bad++; $display("FAIL blank0_an got=%b exp=10001", {blank_seen, seen}); end
                total++; if (n0 !== 4'h0) begin bad++; $display("FAIL blank0_nib got=%h exp=0", n0); end
            end
        end
        capture = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_register_read();
        test_scan_wrap();
        test_timeout();
        test_timeout_tie();
        test_ignored_edge();
        test_reset_mid_read();
`ifdef DBG_DISP_LZ_BLANK_EN
        test_blanking();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
